// File: rtl/block_interleaver.sv
// Bit-serial row/column block interleaver: one frame of ROWS*COLS bits is written
// row-wise in FILL, then read back column-wise in DRAIN.
module block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_valid,
  output logic in_ready,
  input  logic din,
  output logic out_valid,
  input  logic out_ready,
  output logic dout,
  output logic out_first,
  output logic out_last
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [N-1:0]   mem;
  logic [CW-1:0]  wr_c, rd_c;
  logic [RW-1:0]  wr_r, rd_r;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic           in_acc, out_acc;
  logic           wr_last, rd_last;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and clear cancels any transfer in its cycle.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign in_acc    = in_valid && in_ready && !clear;
  assign out_acc   = out_valid && out_ready && !clear;

  assign wr_idx  = AW'(wr_r) * AW'(COLS) + AW'(wr_c);
  assign rd_idx  = AW'(rd_r) * AW'(COLS) + AW'(rd_c);
  assign wr_last = (wr_c == CW'(COLS - 1)) && (wr_r == RW'(ROWS - 1));
  assign rd_last = (rd_c == CW'(COLS - 1)) && (rd_r == RW'(ROWS - 1));

  assign dout      = out_valid ? mem[rd_idx] : 1'b0;
  assign out_first = out_valid && (rd_c == '0) && (rd_r == '0);
  assign out_last  = out_valid && rd_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL:    if (in_acc && wr_last)  state_next = DRAIN;
        DRAIN:   if (out_acc && rd_last) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // Write side: column is the fast index; both wrap to 0 after the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_c <= '0;
      wr_r <= '0;
    end else if (clear) begin
      wr_c <= '0;
      wr_r <= '0;
    end else if (in_acc) begin
      if (wr_c == CW'(COLS - 1)) begin
        wr_c <= '0;
        wr_r <= (wr_r == RW'(ROWS - 1)) ? '0 : wr_r + 1'b1;
      end else begin
        wr_c <= wr_c + 1'b1;
      end
    end
  end

  // Read side: row is the fast index, giving column-wise output order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_c <= '0;
      rd_r <= '0;
    end else if (clear) begin
      rd_c <= '0;
      rd_r <= '0;
    end else if (out_acc) begin
      if (rd_r == RW'(ROWS - 1)) begin
        rd_r <= '0;
        rd_c <= (rd_c == CW'(COLS - 1)) ? '0 : rd_c + 1'b1;
      end else begin
        rd_r <= rd_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mem <= '0;
    else if (in_acc) mem[wr_idx] <= din;
  end

endmodule

// File: doc/block_interleaver.md
Name: block_interleaver

Overview:
- Bit-serial row/column block interleaver for the interleaver datapath.
- Sits directly upstream of the enable-gated flip-flop output register (muxdff) stage, which captures dout when out_valid && out_ready.
- Accepts one frame of ROWS*COLS bits written row-wise, then emits the frame read column-wise.
- Single frame buffer with a two-state FILL/DRAIN controller and valid/ready handshakes on both sides.

Parameters:
ROWS, 4, matrix rows (>=2)
COLS, 8, matrix columns (>=2); frame length N = ROWS*COLS

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
clear  input  1  synchronous abort; discards the current frame and returns to FILL
in_valid  input  1  din is valid this cycle
in_ready  output  1  block accepts din this cycle (high only in FILL)
din  input  1  input bit, frame order k = 0..N-1
out_valid  output  1  dout is valid (high only in DRAIN)
out_ready  input  1  downstream accepts dout (drives the muxdff enable)
dout  output  1  interleaved output bit
out_first  output  1  high with the first output bit of a frame
out_last  output  1  high with the final output bit of a frame

Behaviour:
- Storage: N-bit buffer mem; input bit k is written to mem[k]; write counters wr_c (0..COLS-1) and wr_r (0..ROWS-1); k = wr_r*COLS + wr_c; wr_c is the inner (fast) index.
- Read order: rd_c outer, rd_r inner; output j reads mem[rd_r*COLS + rd_c]. Output sequence for 4x8: k = 0,8,16,24,1,9,17,25,...,7,15,23,31.
- Counter widths: $clog2 of ROWS and COLS (minimum 1 bit); each counter wraps to 0 at its maximum.
- States:
  - FILL (reset state): in_ready = 1, out_valid = 0.
  - DRAIN: in_ready = 0, out_valid = 1.
- FILL: on in_valid && in_ready, write din and advance the write counters. Input accepted at k = N-1 moves the state to DRAIN next cycle, with read counters at 0.
- DRAIN: dout = mem[rd index], combinational from registered counters. On out_valid && out_ready, advance the read counters. Transfer of j = N-1 moves the state to FILL next cycle with all counters at 0.
- Backpressure: while out_valid && !out_ready, dout, out_first and out_last hold stable.
- Gaps: in_valid low in FILL stalls the write counters with no side effects. in_valid in DRAIN is ignored; nothing is written.
- Latency: first out_valid occurs the cycle after the N-th input is accepted. in_ready returns the cycle after the last output is accepted. The block never accepts and emits in the same cycle.
- Flags:
  - out_first = out_valid && rd_c == 0 && rd_r == 0.
  - out_last = out_valid && rd_c == COLS-1 && rd_r == ROWS-1.
- dout is forced to 0 whenever out_valid = 0.
- clear: next state is FILL with all counters at 0. clear has priority over a simultaneous input or output handshake; that handshake does not take effect. mem contents are not cleared; they are overwritten by the next frame.
- reset low (any time, including mid-FILL or mid-DRAIN): state = FILL, all counters = 0, mem = 0.
  - Outputs during reset: in_ready = 1, out_valid = 0, dout = 0, out_first = 0, out_last = 0.
  - Operation resumes on the first rising clk edge after reset deasserts.

Test Plan:
- Row-0 pattern: din = 1 for k = 0..7, else 0; out_ready = 1 throughout -> output is "1000" repeated 8 times. out_first is high with output 0, out_last with output 31, and out_valid first rises 1 cycle after the 32nd input.
- Single-bit probe: din = 1 only at k = 5 -> exactly one output is 1, at output position j = 20 (c=5, r=0). Repeat with k = 30 -> j = 27.
- Backpressure: toggle out_ready 1,0,0,1,... during DRAIN -> no bit is lost or duplicated, dout and the flags hold while stalled, and 32 transfers are counted.
- Input gaps and overlap: in_valid random 50% during FILL, and in_valid = 1 held throughout DRAIN -> in_ready is 0 in DRAIN, no corruption, and the next frame starts in FILL after the last output is accepted.
- clear mid-FILL (after 13 bits) and mid-DRAIN (after 10 outputs), including clear coincident with a handshake -> state returns to FILL and a fresh 32-bit frame interleaves correctly.
- Async reset pulsed low between clock edges during DRAIN -> outputs immediately go to in_ready = 1, out_valid = 0, dout = 0; a full frame after release is correct.
